// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a header + big-endian byte stream into
// 32-bit word writes, holding the CPU off while a frame is being loaded.
module imem_loader #(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        wr_en,
  output logic [30:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int unsigned WCW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOAD = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [7:0]     n_q, n_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [31:0]    shift_q, shift_d;
  logic           wr_en_q, wr_en_d;
  logic [30:0]    wr_addr_q, wr_addr_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic           hold_q, hold_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic hdr_ok;
  logic last_word;
  logic finishing;

  assign hdr_ok    = (byte_data != 8'd0) && (32'(byte_data) <= MEM_WORDS);
  assign last_word = (32'(word_cnt_q) + 32'd1) == 32'(n_q);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    finishing  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (byte_valid) begin
          if (hdr_ok) begin
            state_d    = S_LOAD;
            n_d        = byte_data;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            shift_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        if (byte_valid) begin
          shift_d    = {shift_q[23:0], byte_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = {shift_q[23:0], byte_data};
            wr_addr_d = 31'({word_cnt_q, 2'b00});
            if (last_word) begin
              // Back to IDLE now so a byte in the done cycle is taken as a header.
              state_d    = S_IDLE;
              done_d     = 1'b1;
              finishing  = 1'b1;
              word_cnt_d = '0;
            end else begin
              word_cnt_d = word_cnt_q + WCW'(1);
            end
          end
        end
      end
    endcase

    // Hold stays up through the done cycle, then follows the state.
    hold_d = (state_d == S_LOAD) || finishing;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: per-cycle vector table plus frame sequences, with
// expected word writes queued at stimulus time and popped as writes appear.
module tb_imem_loader;

  logic        clk;
  logic        reset_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        wr_en;
  logic [30:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int vectors;
  int miscompares;

  typedef struct packed {
    logic [30:0] addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic        hold;
    logic        err;
    logic        wr;
    logic [30:0] addr;
    logic [31:0] data;
    logic        last;
  } vec_t;

  wr_t exp_q[$];

  imem_loader #(.MEM_WORDS(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(wr_en), 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", wr_data, e.data);
          chk("done_with_wr", 32'(done), 32'(e.last));
        end
      end else begin
        chk("done_without_wr", 32'(done), 32'd0);
      end
    end
  end

  function automatic vec_t mk(logic v, logic [7:0] d, logic h, logic e, logic w,
                              logic [30:0] a, logic [31:0] dt, logic l);
    vec_t r;
    r.v = v; r.d = d; r.hold = h; r.err = e; r.wr = w;
    r.addr = a; r.data = dt; r.last = l;
    return r;
  endfunction

  task automatic step(input logic v, input logic [7:0] d);
    byte_valid = v;
    byte_data  = d;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  // Full frame of n words with random payload; gap inserts an idle cycle after each byte.
  task automatic run_frame(input int n, input bit gap);
    logic [7:0]  b;
    logic [31:0] w;
    w = '0;
    step(1'b1, 8'(n));
    chk("frame_hdr_hold", 32'(cpu_hold), 32'd1);
    chk("frame_hdr_err", 32'(err), 32'd0);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      w = {w[23:0], b};
      if ((i % 4) == 3) exp_q.push_back('{31'(4 * (i / 4)), w, (i == 4 * n - 1)});
      step(1'b1, b);
      chk("frame_wr_latency", 32'(wr_en), ((i % 4) == 3) ? 32'd1 : 32'd0);
      chk("frame_hold", 32'(cpu_hold), 32'd1);
      if (gap) begin
        step(1'b0, 8'h00);
        chk("frame_gap_wr", 32'(wr_en), 32'd0);
      end
    end
    if (!gap) step(1'b0, 8'h00);
    chk("frame_hold_drop", 32'(cpu_hold), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[24];
    vectors     = 0;
    miscompares = 0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    reset_n     = 1'b0;

    // Basic load with a gap, bad headers, and a header right after an error.
    tbl[0]  = mk(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[1]  = mk(1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[2]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[3]  = mk(1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[4]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[5]  = mk(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 31'h0, 32'h20040003, 1'b0);
    tbl[6]  = mk(1'b1, 8'h0c, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[7]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[8]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[9]  = mk(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 31'h4, 32'h0c000003, 1'b0);
    tbl[10] = mk(1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[11] = mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[12] = mk(1'b1, 8'hff, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[13] = mk(1'b1, 8'hff, 1'b1, 1'b0, 1'b1, 31'h8, 32'h1000ffff, 1'b1);
    tbl[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[15] = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[16] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[17] = mk(1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[18] = mk(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[19] = mk(1'b1, 8'haa, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[20] = mk(1'b1, 8'hbb, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[21] = mk(1'b1, 8'hcc, 1'b1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);
    tbl[22] = mk(1'b1, 8'hdd, 1'b1, 1'b0, 1'b1, 31'h0, 32'haabbccdd, 1'b1);
    tbl[23] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0);

    #2;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      if (tbl[i].wr) exp_q.push_back('{tbl[i].addr, tbl[i].data, tbl[i].last});
      step(tbl[i].v, tbl[i].d);
      chk("tbl_hold", 32'(cpu_hold), 32'(tbl[i].hold));
      chk("tbl_err", 32'(err), 32'(tbl[i].err));
      chk("tbl_wr_en", 32'(wr_en), 32'(tbl[i].wr));
    end

    // Back-to-back, gapped, and the full-capacity boundary frame.
    run_frame(3, 1'b0);
    run_frame(2, 1'b1);
    run_frame(32, 1'b0);

    // Chained frames: second header arrives in the done cycle of the first.
    step(1'b1, 8'h01);
    exp_q.push_back('{31'h0, 32'hdeadbeef, 1'b1});
    step(1'b1, 8'hde);
    step(1'b1, 8'had);
    step(1'b1, 8'hbe);
    step(1'b1, 8'hef);
    chk("chain_wr1", 32'(wr_en), 32'd1);
    chk("chain_hold1", 32'(cpu_hold), 32'd1);
    step(1'b1, 8'h01);
    chk("chain_hdr2_hold", 32'(cpu_hold), 32'd1);
    chk("chain_hdr2_err", 32'(err), 32'd0);
    chk("chain_hdr2_wr", 32'(wr_en), 32'd0);
    exp_q.push_back('{31'h0, 32'h01020304, 1'b1});
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    step(1'b1, 8'h04);
    chk("chain_wr2", 32'(wr_en), 32'd1);
    step(1'b0, 8'h00);
    chk("chain_hold_drop", 32'(cpu_hold), 32'd0);

    // Reset mid-load: one word written, the partial second word is discarded.
    step(1'b1, 8'h02);
    exp_q.push_back('{31'h0, 32'h11223344, 1'b0});
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    step(1'b1, 8'h44);
    chk("mid_wr", 32'(wr_en), 32'd1);
    step(1'b1, 8'h55);
    step(1'b1, 8'h66);
    chk("mid_hold_before", 32'(cpu_hold), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00);
      chk("post_rst_wr", 32'(wr_en), 32'd0);
      chk("post_rst_hold", 32'(cpu_hold), 32'd0);
    end
    run_frame(1, 1'b0);

    step(1'b0, 8'h00);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
